// File: rtl/branch_predictor_ctrl_pkg.sv
// Shared types for the bimodal predictor controller: counter, pending-update record,
// init value and the saturating counter step.
package branch_predictor_ctrl_pkg;

  localparam int LC3B_P_INDEX_W = 5;

  typedef logic [1:0]                bp_ctr_t;
  typedef logic [LC3B_P_INDEX_W-1:0] bp_idx_t;

  typedef struct packed {
    bp_idx_t index;
    logic    taken;
  } bp_upd_t;

  localparam bp_ctr_t BP_INIT_VAL = 2'b10;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bp_state_t;

  function automatic bp_ctr_t bp_next(input bp_ctr_t cur, input logic taken);
    bp_ctr_t nxt;
    nxt = cur;
    if (taken) begin
      if (cur != 2'b11) nxt = cur + 2'b01;
    end else begin
      if (cur != 2'b00) nxt = cur - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_ctrl_if.sv
// Fetch, execute and counter-table signals of the predictor controller.
// slave: the controller side; master: fetch/execute/table side.
interface branch_predictor_ctrl_if
  import branch_predictor_ctrl_pkg::*;
#(
  parameter int IDX_W = LC3B_P_INDEX_W
) ();

  logic             lookup_req;
  logic [IDX_W-1:0] lookup_index;
  logic             lookup_grant;
  bp_ctr_t          pred_count;
  logic             pred_taken;

  logic             resolve_valid;
  logic [IDX_W-1:0] resolve_index;
  logic             resolve_taken;
  logic             resolve_ready;

  logic [IDX_W-1:0] tbl_rindex;
  bp_ctr_t          tbl_rdata;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_windex;
  bp_ctr_t          tbl_wdata;

  logic             init_busy;

  modport slave (
    input  lookup_req, lookup_index, resolve_valid, resolve_index, resolve_taken, tbl_rdata,
    output lookup_grant, pred_count, pred_taken, resolve_ready,
    output tbl_rindex, tbl_we, tbl_windex, tbl_wdata, init_busy
  );

  modport master (
    output lookup_req, lookup_index, resolve_valid, resolve_index, resolve_taken, tbl_rdata,
    input  lookup_grant, pred_count, pred_taken, resolve_ready,
    input  tbl_rindex, tbl_we, tbl_windex, tbl_wdata, init_busy
  );

endinterface

// File: rtl/branch_predictor_ctrl_fifo.sv
// Pending-update FIFO (bp_upd_t entries) with occupancy count, full and empty.
// Head is visible combinationally; push while full and pop while empty are dropped.
module bp_update_fifo
  import branch_predictor_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  bp_upd_t                push_dat_i,
  input  logic                   pop_i,
  output bp_upd_t                head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  bp_upd_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/branch_predictor_ctrl.sv
// Bimodal counter table sequencer: init sweep, read-port arbitration, saturating RMW.
// Optional BP_STATS_EN adds saturating stat_updates / stat_stalls counters.
module branch_predictor_ctrl
  import branch_predictor_ctrl_pkg::*;
#(
  parameter int      IDX_W      = LC3B_P_INDEX_W,
  parameter int      FIFO_DEPTH = 4,
  parameter bp_ctr_t INIT_VAL   = BP_INIT_VAL
) (
  input  logic                   clk,
  input  logic                   rst_n,
  branch_predictor_ctrl_if.slave bp
`ifdef BP_STATS_EN
  ,
  output logic [15:0]            stat_updates,
  output logic [15:0]            stat_stalls
`endif
);

  localparam int               CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  bp_state_t        state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  bp_upd_t          head;
  bp_upd_t          push_dat;
  logic             push;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             run;
  logic             upd_win;

  assign run      = (state_q == ST_RUN);
  assign push_dat = '{index: bp.resolve_index, taken: bp.resolve_taken};

  // Ready reflects occupancy before any same-cycle pop.
  assign bp.resolve_ready = run & (count < CNT_W'(FIFO_DEPTH));
  assign push             = bp.resolve_valid & bp.resolve_ready;

  assign upd_win = run & ~empty & (~bp.lookup_req | full);

  bp_update_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (upd_win),
    .head_o     (head),
    .count_o    (count),
    .full_o     (full),
    .empty_o    (empty)
  );

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    bp.tbl_we       = 1'b0;
    bp.tbl_windex   = ptr_q;
    bp.tbl_wdata    = INIT_VAL;
    bp.tbl_rindex   = bp.lookup_index;
    bp.lookup_grant = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        // Hold off sweep writes while reset is still asserted.
        bp.tbl_we = rst_n;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == LAST_IDX) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (upd_win) begin
          bp.tbl_rindex = head.index;
          bp.tbl_we     = 1'b1;
          bp.tbl_windex = head.index;
          bp.tbl_wdata  = bp_next(bp.tbl_rdata, head.taken);
        end else begin
          bp.lookup_grant = bp.lookup_req;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bp.init_busy  = ~run;
  assign bp.pred_count = bp.lookup_grant ? bp.tbl_rdata : 2'b00;
  assign bp.pred_taken = bp.pred_count[1];

  a_one_port_user: assert property (@(posedge clk) disable iff (!rst_n)
    !(bp.tbl_we && bp.lookup_grant));

`ifdef BP_STATS_EN
  logic [15:0] stat_updates_q;
  logic [15:0] stat_stalls_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_updates_q <= '0;
      stat_stalls_q  <= '0;
    end else begin
      if (upd_win && stat_updates_q != 16'hFFFF)
        stat_updates_q <= stat_updates_q + 16'd1;
      if (run && bp.lookup_req && !bp.lookup_grant && stat_stalls_q != 16'hFFFF)
        stat_stalls_q <= stat_stalls_q + 16'd1;
    end
  end

  assign stat_updates = stat_updates_q;
  assign stat_stalls  = stat_stalls_q;
`endif

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Randomized bench for branch_predictor_ctrl against a queue-and-array reference model.
`timescale 1ns/1ps
module tb_branch_predictor_ctrl;
  import branch_predictor_ctrl_pkg::*;

  localparam int IDX_W = 5;
  localparam int TBL_N = 32;
  localparam int FD    = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_predictor_ctrl_if #(.IDX_W(IDX_W)) bp_if_i ();

`ifdef BP_STATS_EN
  logic [15:0] stat_updates;
  logic [15:0] stat_stalls;
`endif

  branch_predictor_ctrl #(
    .IDX_W      (IDX_W),
    .FIFO_DEPTH (FD),
    .INIT_VAL   (2'b10)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bp           (bp_if_i)
`ifdef BP_STATS_EN
    ,
    .stat_updates (stat_updates),
    .stat_stalls  (stat_stalls)
`endif
  );

  // Counter array seen by the controller.
  logic [1:0] mem [TBL_N];
  assign bp_if_i.tbl_rdata = mem[bp_if_i.tbl_rindex];
  always @(posedge clk) if (bp_if_i.tbl_we) mem[bp_if_i.tbl_windex] <= bp_if_i.tbl_wdata;

  // Reference model: expected counters, pending updates in push order, stat counts.
  int exp_tbl [TBL_N];
  int q_idx [$];
  bit q_tk [$];
  int exp_upd;
  int exp_stall;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit lr, input int li, input bit rv, input int ri, input bit rt);
    bp_if_i.lookup_req    = lr;
    bp_if_i.lookup_index  = li[IDX_W-1:0];
    bp_if_i.resolve_valid = rv;
    bp_if_i.resolve_index = ri[IDX_W-1:0];
    bp_if_i.resolve_taken = rt;
  endtask

  // One RUN cycle: entered just after a posedge, leaves just after the next one.
  task automatic step(input bit lr, input int li, input bit rv, input int ri, input bit rt);
    bit win, rdy;
    int ei, nv;
    ei = 0;
    nv = 0;
    drive(lr, li, rv, ri, rt);
    @(negedge clk);
    rdy = (q_idx.size() < FD);
    win = (q_idx.size() > 0) && (!lr || q_idx.size() == FD);
    check_eq("resolve_ready", bp_if_i.resolve_ready, rdy);
    check_eq("lookup_grant", bp_if_i.lookup_grant, lr && !win);
    check_eq("tbl_we", bp_if_i.tbl_we, win);
    check_eq("init_busy", bp_if_i.init_busy, 1'b0);
    if (win) begin
      ei = q_idx[0];
      if (q_tk[0]) nv = (exp_tbl[ei] == 3) ? 3 : exp_tbl[ei] + 1;
      else         nv = (exp_tbl[ei] == 0) ? 0 : exp_tbl[ei] - 1;
      check_eq("tbl_windex", bp_if_i.tbl_windex, ei);
      check_eq("tbl_wdata", bp_if_i.tbl_wdata, nv);
      check_eq("pred_count_upd", bp_if_i.pred_count, 0);
    end else if (lr) begin
      check_eq("pred_count", bp_if_i.pred_count, exp_tbl[li % TBL_N]);
      check_eq("pred_taken", bp_if_i.pred_taken, exp_tbl[li % TBL_N] >= 2);
    end else begin
      check_eq("pred_idle", {bp_if_i.pred_taken, bp_if_i.pred_count}, 0);
    end
`ifdef BP_STATS_EN
    check_eq("stat_updates", stat_updates, exp_upd);
    check_eq("stat_stalls", stat_stalls, exp_stall);
`endif
    @(posedge clk);
    if (win) begin
      exp_tbl[ei] = nv;
      void'(q_idx.pop_front());
      void'(q_tk.pop_front());
      if (exp_upd < 16'hFFFF) exp_upd++;
    end
    if (lr && win && exp_stall < 16'hFFFF) exp_stall++;
    if (rv && rdy) begin
      q_idx.push_back(ri % TBL_N);
      q_tk.push_back(rt);
    end
    #1;
  endtask

  task automatic sweep(input int n);
    for (int i = 0; i < n; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, TBL_N - 1), $urandom_range(0, 1),
            $urandom_range(0, TBL_N - 1), $urandom_range(0, 1));
      @(negedge clk);
      check_eq("init_we", bp_if_i.tbl_we, 1'b1);
      check_eq("init_windex", bp_if_i.tbl_windex, i);
      check_eq("init_wdata", bp_if_i.tbl_wdata, 2'b10);
      check_eq("init_busy_sweep", bp_if_i.init_busy, 1'b1);
      check_eq("init_ready", bp_if_i.resolve_ready, 1'b0);
      check_eq("init_grant", bp_if_i.lookup_grant, 1'b0);
      @(posedge clk);
      #1;
    end
    if (n == TBL_N) foreach (exp_tbl[i]) exp_tbl[i] = 2;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(1'b1, 7, 1'b1, 3, 1'b1);
    #1;
    check_eq("rst_we", bp_if_i.tbl_we, 1'b0);
    check_eq("rst_grant", bp_if_i.lookup_grant, 1'b0);
    check_eq("rst_ready", bp_if_i.resolve_ready, 1'b0);
    check_eq("rst_pred", {bp_if_i.pred_taken, bp_if_i.pred_count}, 0);
    check_eq("rst_busy", bp_if_i.init_busy, 1'b1);
    @(posedge clk);
    #1;
    check_eq("rst_we_hold", bp_if_i.tbl_we, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q_idx.delete();
    q_tk.delete();
    exp_upd   = 0;
    exp_stall = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 0, 1'b0, 0, 1'b0);
    exp_upd   = 0;
    exp_stall = 0;
    foreach (exp_tbl[i]) exp_tbl[i] = 2;
    @(posedge clk);
    #1;
    apply_reset();
    sweep(TBL_N);

    // Lookup of a freshly initialised entry.
    step(1'b1, 7, 1'b0, 0, 1'b0);

    // Taken updates saturate at 11; not-taken updates floor at 00.
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 3, 1'b1);
    idle(2);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 9, 1'b0);
    idle(2);
    step(1'b1, 3, 1'b0, 0, 1'b0);
    step(1'b1, 9, 1'b0, 0, 1'b0);

    // Lookups held high while the FIFO fills; full forces an update.
    for (int i = 0; i < FD; i++) step(1'b1, 5, 1'b1, 12 + i, i[0]);
    step(1'b1, 5, 1'b0, 0, 1'b0);
    step(1'b1, 5, 1'b1, 20, 1'b1);
    step(1'b1, 5, 1'b0, 0, 1'b0);
    idle(FD + 1);

    // Same-index back-to-back updates while a lookup of that index is pending.
    for (int i = 0; i < FD; i++) step(1'b1, 14, 1'b1, 14, 1'b0);
    step(1'b1, 14, 1'b0, 0, 1'b0);
    idle(FD + 1);

    // Reset mid-sweep, then mid-update.
    apply_reset();
    sweep(12);
    apply_reset();
    sweep(TBL_N);
    for (int i = 0; i < FD; i++) step(1'b1, 1, 1'b1, 2, 1'b0);
    apply_reset();
    sweep(TBL_N);
    idle(3);

    // Random traffic, sometimes confined to a few indices to force collisions.
    for (int i = 0; i < 1500; i++) begin
      int span;
      span = ($urandom_range(0, 3) == 0) ? 4 : TBL_N;
      step($urandom_range(0, 1), $urandom_range(0, span - 1),
           $urandom_range(0, 2) != 0, $urandom_range(0, span - 1), $urandom_range(0, 1));
    end
    idle(FD + 2);

    foreach (exp_tbl[i]) check_eq($sformatf("table[%0d]", i), mem[i], exp_tbl[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
